// File: rtl/jpeg_mod_pkg.sv
// Shared constants and types for the JPEG_MOD pixel pipeline.
package jpeg_mod_pkg;

  localparam int BLOCK_SIZE   = 8;
  localparam int PIX_PER_BEAT = 2;

  // Packed {cb, cr, y} so the word layout matches blocks_to_hdmi; lane 0 is the leftmost pixel.
  typedef struct packed {
    logic signed [PIX_PER_BEAT-1:0][7:0] cb;
    logic signed [PIX_PER_BEAT-1:0][7:0] cr;
    logic signed [PIX_PER_BEAT-1:0][7:0] y;
  } pix_beat_t;

  typedef enum logic {
    WR_WAIT_FRAME,
    WR_LINES
  } wr_state_e;

  typedef enum logic {
    RD_IDLE,
    RD_READ
  } rd_state_e;

endpackage

// File: rtl/stripe_ram.sv
// Simple dual-port stripe buffer: one write port, one read port with a registered output.
module stripe_ram #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 48,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // NOTE: the array and read register carry no reset so they map onto block RAM;
  // sequential state is always assigned with <= so every read sees pre-edge values.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/hdmi_to_blocks.sv
// Raster HDMI pixel stream to 8x8 block stream: each 8-line stripe is written into one of two
// ping-pong RAMs while the previously completed stripe is read out block by block.
module hdmi_to_blocks
  import jpeg_mod_pkg::*;
#(
  parameter int N     = PIX_PER_BEAT,
  parameter int X_RES = 2160,
  parameter int Y_RES = 1200
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     hdmi_v_sync,
  input  logic                     hdmi_h_sync,
  input  logic                     hdmi_data_valid,
  input  logic signed [N-1:0][7:0] hdmi_data_y,
  input  logic signed [N-1:0][7:0] hdmi_data_cr,
  input  logic signed [N-1:0][7:0] hdmi_data_cb,
  output logic                     blk_valid,
  output logic signed [N-1:0][7:0] blk_data_y,
  output logic signed [N-1:0][7:0] blk_data_cr,
  output logic signed [N-1:0][7:0] blk_data_cb,
  output logic                     blk_sob,
  output logic                     blk_eob,
  output logic                     blk_sof,
  output logic                     err_line_len,
  output logic                     err_frame_len,
  output logic                     err_overflow
);

  localparam int BEATS_PER_LINE = X_RES / N;
  localparam int BEATS_PER_ROW  = BLOCK_SIZE / N;
  localparam int BLOCKS         = X_RES / BLOCK_SIZE;
  localparam int DEPTH          = BEATS_PER_LINE * BLOCK_SIZE;
  localparam int AW             = $clog2(DEPTH);
  localparam int XW             = $clog2(BEATS_PER_LINE + 2);
  localparam int LW             = $clog2(Y_RES);
  localparam int BW             = (BLOCKS > 1) ? $clog2(BLOCKS) : 1;
  localparam int EW             = (BEATS_PER_ROW > 1) ? $clog2(BEATS_PER_ROW) : 1;
  localparam int WW             = 24 * N;

  logic unused;
  assign unused = hdmi_h_sync;

  logic vs_q, dv_q;
  logic vs_rise, line_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_q <= 1'b0;
      dv_q <= 1'b0;
    end else begin
      vs_q <= hdmi_v_sync;
      dv_q <= hdmi_data_valid;
    end
  end

  assign vs_rise  = hdmi_v_sync & ~vs_q;
  assign line_end = dv_q & ~hdmi_data_valid;

  // ---------------- writer ----------------
  wr_state_e     wr_state_q, wr_state_d;
  logic [LW-1:0] line_q, line_d;
  logic [XW-1:0] x_q, x_d;
  logic          wr_buf_q, wr_buf_d;
  logic          stripe_done_q, stripe_done_d;
  logic          stripe_first_q, stripe_first_d;
  logic          err_line_q, err_line_d;
  logic          err_frame_q, err_frame_d;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [WW-1:0] wr_word;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_q     <= WR_WAIT_FRAME;
      line_q         <= '0;
      x_q            <= '0;
      wr_buf_q       <= 1'b0;
      stripe_done_q  <= 1'b0;
      stripe_first_q <= 1'b0;
      err_line_q     <= 1'b0;
      err_frame_q    <= 1'b0;
    end else begin
      wr_state_q     <= wr_state_d;
      line_q         <= line_d;
      x_q            <= x_d;
      wr_buf_q       <= wr_buf_d;
      stripe_done_q  <= stripe_done_d;
      stripe_first_q <= stripe_first_d;
      err_line_q     <= err_line_d;
      err_frame_q    <= err_frame_d;
    end
  end

  // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
  always_comb begin
    wr_state_d = wr_state_q;
    unique case (wr_state_q)
      WR_WAIT_FRAME: if (vs_rise && en) wr_state_d = WR_LINES;
      WR_LINES: begin
        if (vs_rise) wr_state_d = en ? WR_LINES : WR_WAIT_FRAME;
        else if (line_end && line_q == LW'(Y_RES - 1)) wr_state_d = WR_WAIT_FRAME;
      end
      default: wr_state_d = WR_WAIT_FRAME;
    endcase
  end

  always_comb begin
    line_d         = line_q;
    x_d            = x_q;
    wr_buf_d       = wr_buf_q;
    stripe_done_d  = 1'b0;
    stripe_first_d = stripe_first_q;
    err_line_d     = err_line_q;
    err_frame_d    = err_frame_q;
    wr_en          = 1'b0;
    if (vs_rise) begin
      // A partial stripe is simply overwritten by the restarted frame.
      line_d = '0;
      x_d    = '0;
      if (wr_state_q == WR_LINES) err_frame_d = 1'b1;
    end else if (wr_state_q == WR_LINES) begin
      if (hdmi_data_valid) begin
        wr_en = (x_q < XW'(BEATS_PER_LINE));
        if (x_q <= XW'(BEATS_PER_LINE)) x_d = x_q + XW'(1);
      end
      if (line_end) begin
        if (x_q != XW'(BEATS_PER_LINE)) err_line_d = 1'b1;
        x_d    = '0;
        line_d = line_q + LW'(1);
        if (line_q[2:0] == 3'd7) begin
          stripe_done_d  = 1'b1;
          stripe_first_d = ((line_q >> 3) == '0);
          wr_buf_d       = ~wr_buf_q;
        end
      end
    end
  end

  assign wr_addr = AW'(int'(line_q[2:0]) * BEATS_PER_LINE + int'(x_q));
  assign wr_word = {hdmi_data_cb, hdmi_data_cr, hdmi_data_y};

  // ---------------- reader ----------------
  rd_state_e     rd_state_q, rd_state_d;
  logic [BW-1:0] b_q, b_d;
  logic [2:0]    r_q, r_d;
  logic [EW-1:0] e_q, e_d;
  logic          rd_buf_q, rd_buf_d;
  logic          rd_first_q, rd_first_d;
  logic          err_ovf_q, err_ovf_d;
  logic          s1_valid_q, s1_valid_d;
  logic          s1_sob_q, s1_sob_d;
  logic          s1_eob_q, s1_eob_d;
  logic          s1_sof_q, s1_sof_d;
  logic          s1_buf_q, s1_buf_d;
  logic          rd_active, rd_last, row_first;
  logic [AW-1:0] rd_addr;
  logic [WW-1:0] rd_word0, rd_word1;

  assign rd_active = (rd_state_q == RD_READ);
  assign row_first = (r_q == 3'd0) && (e_q == '0);
  assign rd_last   = rd_active && (b_q == BW'(BLOCKS - 1)) && (r_q == 3'd7)
                     && (e_q == EW'(BEATS_PER_ROW - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_q <= RD_IDLE;
      b_q        <= '0;
      r_q        <= '0;
      e_q        <= '0;
      rd_buf_q   <= 1'b0;
      rd_first_q <= 1'b0;
      err_ovf_q  <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_sob_q   <= 1'b0;
      s1_eob_q   <= 1'b0;
      s1_sof_q   <= 1'b0;
      s1_buf_q   <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      b_q        <= b_d;
      r_q        <= r_d;
      e_q        <= e_d;
      rd_buf_q   <= rd_buf_d;
      rd_first_q <= rd_first_d;
      err_ovf_q  <= err_ovf_d;
      s1_valid_q <= s1_valid_d;
      s1_sob_q   <= s1_sob_d;
      s1_eob_q   <= s1_eob_d;
      s1_sof_q   <= s1_sof_d;
      s1_buf_q   <= s1_buf_d;
    end
  end

  always_comb begin
    rd_state_d = rd_state_q;
    if (stripe_done_q) rd_state_d = RD_READ;
    else if (rd_last) rd_state_d = RD_IDLE;
  end

  always_comb begin
    b_d        = b_q;
    r_d        = r_q;
    e_d        = e_q;
    rd_buf_d   = rd_buf_q;
    rd_first_d = rd_first_q;
    err_ovf_d  = err_ovf_q;
    if (stripe_done_q) begin
      // wr_buf has already toggled, so the completed stripe sits in the other RAM.
      b_d        = '0;
      r_d        = '0;
      e_d        = '0;
      rd_buf_d   = ~wr_buf_q;
      rd_first_d = stripe_first_q;
      if (rd_active && !rd_last) err_ovf_d = 1'b1;
    end else if (rd_active) begin
      if (e_q == EW'(BEATS_PER_ROW - 1)) begin
        e_d = '0;
        if (r_q == 3'd7) begin
          r_d = '0;
          b_d = (b_q == BW'(BLOCKS - 1)) ? '0 : b_q + BW'(1);
        end else begin
          r_d = r_q + 3'd1;
        end
      end else begin
        e_d = e_q + EW'(1);
      end
    end
    s1_valid_d = rd_active;
    s1_sob_d   = row_first;
    s1_eob_d   = (r_q == 3'd7) && (e_q == EW'(BEATS_PER_ROW - 1));
    s1_sof_d   = rd_first_q && row_first && (b_q == '0);
    s1_buf_d   = rd_buf_q;
  end

  assign rd_addr = AW'(int'(r_q) * BEATS_PER_LINE + int'(b_q) * BEATS_PER_ROW + int'(e_q));

  stripe_ram #(.DEPTH(DEPTH), .WIDTH(WW)) u_ram0 (
    .clk     (clk),
    .we      (wr_en & ~wr_buf_q),
    .wr_addr (wr_addr),
    .wr_data (wr_word),
    .rd_en   (rd_active),
    .rd_addr (rd_addr),
    .rd_data (rd_word0)
  );

  stripe_ram #(.DEPTH(DEPTH), .WIDTH(WW)) u_ram1 (
    .clk     (clk),
    .we      (wr_en & wr_buf_q),
    .wr_addr (wr_addr),
    .wr_data (wr_word),
    .rd_en   (rd_active),
    .rd_addr (rd_addr),
    .rd_data (rd_word1)
  );

  assign blk_valid = s1_valid_q;
  assign blk_sob   = s1_valid_q & s1_sob_q;
  assign blk_eob   = s1_valid_q & s1_eob_q;
  assign blk_sof   = s1_valid_q & s1_sof_q;
  assign {blk_data_cb, blk_data_cr, blk_data_y} =
      s1_valid_q ? (s1_buf_q ? rd_word1 : rd_word0) : '0;

  assign err_line_len  = err_line_q;
  assign err_frame_len = err_frame_q;
  assign err_overflow  = err_ovf_q;

endmodule

// File: tb/tb_hdmi_to_blocks.sv
// Self-checking bench for hdmi_to_blocks: scenario table plus hand-written corner sequences,
// compared against a pixel-image reference model of block ordering.
module tb_hdmi_to_blocks;
  import jpeg_mod_pkg::*;

  localparam int N     = 2;
  localparam int X_RES = 16;
  localparam int Y_RES = 16;
  localparam int BPL   = X_RES / N;
  localparam int BPR   = 8 / N;
  localparam int BPS   = X_RES / 8;
  localparam int STRIPE_BEATS = BPL * 8;

  logic clk = 1'b0;
  logic rst, en, hdmi_v_sync, hdmi_h_sync, hdmi_data_valid;
  logic signed [N-1:0][7:0] hdmi_data_y, hdmi_data_cr, hdmi_data_cb;
  logic blk_valid, blk_sob, blk_eob, blk_sof;
  logic signed [N-1:0][7:0] blk_data_y, blk_data_cr, blk_data_cb;
  logic err_line_len, err_frame_len, err_overflow;

  always #5 clk = ~clk;

  hdmi_to_blocks #(.N(N), .X_RES(X_RES), .Y_RES(Y_RES)) dut (
    .clk(clk), .rst(rst), .en(en),
    .hdmi_v_sync(hdmi_v_sync), .hdmi_h_sync(hdmi_h_sync), .hdmi_data_valid(hdmi_data_valid),
    .hdmi_data_y(hdmi_data_y), .hdmi_data_cr(hdmi_data_cr), .hdmi_data_cb(hdmi_data_cb),
    .blk_valid(blk_valid), .blk_data_y(blk_data_y), .blk_data_cr(blk_data_cr),
    .blk_data_cb(blk_data_cb), .blk_sob(blk_sob), .blk_eob(blk_eob), .blk_sof(blk_sof),
    .err_line_len(err_line_len), .err_frame_len(err_frame_len), .err_overflow(err_overflow)
  );

  typedef struct {
    logic [47:0] data;
    logic [2:0]  flags;  // {sof, sob, eob}
    int          cyc;
    bit          known;
  } beat_t;

  typedef struct {
    bit en;
    int n_lines;
    int short_line;
    int long_line;
    bit ramp;
    int exp_blocks;
    int exp_err_line;  // -1: not checked
    bit exp_err_frame;
  } vec_t;

  beat_t got_q[$];
  beat_t exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  logic [7:0] img_y [Y_RES][X_RES];
  logic [7:0] img_cr[Y_RES][X_RES];
  logic [7:0] img_cb[Y_RES][X_RES];
  bit         known [Y_RES][BPL];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    beat_t bt;
    if (blk_valid) begin
      bt.data  = {blk_data_cb, blk_data_cr, blk_data_y};
      bt.flags = {blk_sof, blk_sob, blk_eob};
      bt.cyc   = cyc;
      bt.known = 1'b1;
      got_q.push_back(bt);
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b0; hdmi_v_sync = 1'b0; hdmi_data_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    got_q.delete();
    exp_q.delete();
  endtask

  // Drives one frame; line lengths may be short/long. en is raised after line 1 regardless.
  task automatic send_frame(input bit en_vs, input int n_lines, input int short_line,
                            input int long_line, input int gap, input bit ramp);
    int nb;
    foreach (known[r, c]) known[r][c] = 1'b0;
    @(negedge clk);
    en = en_vs;
    hdmi_v_sync = 1'b1;
    @(negedge clk);
    hdmi_v_sync = 1'b0;
    for (int l = 0; l < n_lines; l++) begin
      nb = (l == short_line) ? BPL - 1 : (l == long_line) ? BPL + 1 : BPL;
      for (int x = 0; x < nb; x++) begin
        @(negedge clk);
        hdmi_data_valid = 1'b1;
        for (int k = 0; k < N; k++) begin
          hdmi_data_y[k]  = ramp ? 8'(l * X_RES + x * N + k) : 8'($urandom);
          hdmi_data_cr[k] = 8'($urandom);
          hdmi_data_cb[k] = 8'($urandom);
          if (x < BPL) begin
            img_y[l][x*N+k]  = hdmi_data_y[k];
            img_cr[l][x*N+k] = hdmi_data_cr[k];
            img_cb[l][x*N+k] = hdmi_data_cb[k];
          end
        end
        if (x < BPL) known[l][x] = 1'b1;
      end
      @(negedge clk);
      hdmi_data_valid = 1'b0;
      repeat (gap - 1) @(negedge clk);
      if (l == 1) en = 1'b1;
    end
  endtask

  // Block order of the captured image: stripe, block, row, element.
  task automatic expect_frame(input int n_stripes);
    beat_t     bt;
    pix_beat_t pb;
    int        row, bx;
    for (int s = 0; s < n_stripes; s++)
      for (int b = 0; b < BPS; b++)
        for (int r = 0; r < 8; r++)
          for (int e = 0; e < BPR; e++) begin
            row = s * 8 + r;
            bx  = b * BPR + e;
            for (int k = 0; k < N; k++) begin
              pb.y[k]  = img_y[row][bx*N+k];
              pb.cr[k] = img_cr[row][bx*N+k];
              pb.cb[k] = img_cb[row][bx*N+k];
            end
            bt.data  = pb;
            bt.known = known[row][bx];
            bt.flags = {(s == 0 && b == 0 && r == 0 && e == 0), (r == 0 && e == 0),
                        (r == 7 && e == BPR - 1)};
            bt.cyc   = 0;
            exp_q.push_back(bt);
          end
  endtask

  task automatic compare_stream(input string tag, input int exp_blocks);
    int nsob = 0;
    foreach (got_q[i]) if (got_q[i].flags[1]) nsob++;
    check({tag, " blocks"}, 64'(nsob), 64'(exp_blocks));
    check({tag, " beats"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      if (exp_q[i].known)
        check($sformatf("%s data[%0d]", tag, i), 64'(got_q[i].data), 64'(exp_q[i].data));
      check($sformatf("%s flags[%0d]", tag, i), 64'(got_q[i].flags), 64'(exp_q[i].flags));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  vec_t vecs[6];

  initial begin
    int nsof, nsob, neob, t;
    vecs[0] = '{1'b1, 16, -1, -1, 1'b0, 4,  0, 1'b0};
    vecs[1] = '{1'b0, 16, -1, -1, 1'b0, 0,  0, 1'b0};
    vecs[2] = '{1'b1, 16,  3, -1, 1'b1, 4,  1, 1'b0};
    vecs[3] = '{1'b1, 16, -1,  3, 1'b1, 4, -1, 1'b0};
    vecs[4] = '{1'b1, 12, -1, -1, 1'b0, 2,  0, 1'b1};
    vecs[5] = '{1'b1,  8, -1, -1, 1'b0, 2,  0, 1'b1};

    rst = 1'b1; en = 1'b0; hdmi_v_sync = 1'b0; hdmi_h_sync = 1'b0; hdmi_data_valid = 1'b0;
    hdmi_data_y = '0; hdmi_data_cr = '0; hdmi_data_cb = '0;
    repeat (3) @(negedge clk);
    check("reset valid", 64'(blk_valid), 64'(0));
    check("reset flags", 64'({blk_sof, blk_sob, blk_eob}), 64'(0));
    check("reset errs", 64'({err_line_len, err_frame_len, err_overflow}), 64'(0));
    check("reset data", 64'({blk_data_cb, blk_data_cr, blk_data_y}), 64'(0));
    rst = 1'b0;

    // Ramp frame: exact block positions and flag counts.
    send_frame(1'b1, 16, -1, -1, 4, 1'b1);
    expect_frame(2);
    repeat (150) @(negedge clk);
    nsof = 0; nsob = 0; neob = 0;
    foreach (got_q[i]) begin
      nsof += int'(got_q[i].flags[2]);
      nsob += int'(got_q[i].flags[1]);
      neob += int'(got_q[i].flags[0]);
    end
    check("ramp sof count", 64'(nsof), 64'(1));
    check("ramp sob count", 64'(nsob), 64'(4));
    check("ramp eob count", 64'(neob), 64'(4));
    check("ramp blk1 first y", 64'(got_q[32].data[15:0]), 64'(16'h0908));
    check("ramp blk1 row1 y", 64'(got_q[32+BPR].data[15:0]), 64'(16'h1918));
    check("ramp errs", 64'({err_line_len, err_frame_len, err_overflow}), 64'(0));
    compare_stream("ramp", 4);

    // Scenario table: frame A as listed, followed by a normal full frame.
    for (int v = 0; v < 6; v++) begin
      do_reset();
      send_frame(vecs[v].en, vecs[v].n_lines, vecs[v].short_line, vecs[v].long_line, 4,
                 vecs[v].ramp);
      expect_frame(vecs[v].exp_blocks / BPS);
      send_frame(1'b1, 16, -1, -1, 4, 1'b0);
      expect_frame(2);
      repeat (150) @(negedge clk);
      compare_stream($sformatf("vec%0d", v), vecs[v].exp_blocks + 4);
      if (vecs[v].exp_err_line >= 0)
        check($sformatf("vec%0d err_line_len", v), 64'(err_line_len), 64'(vecs[v].exp_err_line));
      check($sformatf("vec%0d err_frame_len", v), 64'(err_frame_len), 64'(vecs[v].exp_err_frame));
      check($sformatf("vec%0d err_overflow", v), 64'(err_overflow), 64'(0));
    end

    // Reset during stripe 1 readout, with a sticky error already raised.
    do_reset();
    send_frame(1'b1, 16, 5, -1, 4, 1'b0);
    t = 0;
    while (got_q.size() < STRIPE_BEATS + 10 && t < 400) begin
      @(negedge clk);
      t++;
    end
    check("rst wait stripe1", 64'(got_q.size() >= STRIPE_BEATS + 10), 64'(1));
    check("rst pre err_line_len", 64'(err_line_len), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    check("rst valid", 64'(blk_valid), 64'(0));
    check("rst flags", 64'({blk_sof, blk_sob, blk_eob}), 64'(0));
    check("rst errs", 64'({err_line_len, err_frame_len, err_overflow}), 64'(0));
    rst = 1'b0;
    got_q.delete();
    exp_q.delete();
    send_frame(1'b1, 16, -1, -1, 4, 1'b0);
    expect_frame(2);
    repeat (150) @(negedge clk);
    compare_stream("post-rst", 4);

    // Back-to-back frames with 1-cycle line gaps.
    do_reset();
    send_frame(1'b1, 16, -1, -1, 1, 1'b0);
    expect_frame(2);
    send_frame(1'b1, 16, -1, -1, 1, 1'b0);
    expect_frame(2);
    repeat (150) @(negedge clk);
    check("b2b err_overflow", 64'(err_overflow), 64'(0));
    for (int s = 0; s < 4; s++)
      check($sformatf("b2b stripe%0d span", s),
            64'(got_q[s*STRIPE_BEATS+STRIPE_BEATS-1].cyc - got_q[s*STRIPE_BEATS].cyc),
            64'(STRIPE_BEATS - 1));
    compare_stream("b2b", 8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
